booth_op_sequencer: RTL and testbench
=====================================

Name: booth_op_sequencer

Overview:
Upstream front end for the Booth multiplier control/datapath pair. It accepts signed operand pairs on a valid/ready handshake and drives the core's start and 16-bit data_in bus in the required order: multiplier into Q first, then multiplicand into M. It then waits for the core's done, captures the 32-bit {A,Q} product and presents it on a valid/ready result port. The core itself has no handshake; this block supplies one.

Parameters:
WIDTH, 16, operand width; must match the core's data_in width; product is 2*WIDTH.
TIMEOUT_CYCLES, 80, RUN-state cycle limit before abort (used only with the optional feature); must be at least 3*WIDTH+4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept a pair.
in_mplr  input  WIDTH  multiplier (loaded into Q), two's complement.
in_mcand  input  WIDTH  multiplicand (loaded into M), two's complement.
mul_start  output  1  to core start; low forces core to s0.
mul_data_in  output  WIDTH  to core data_in.
mul_done  input  1  from core done.
mul_product  input  2*WIDTH  from datapath {A,Q}.
res_valid  output  1  result held.
res_ready  input  1  consumer takes result.
res_data  output  2*WIDTH  captured signed product.
res_err  output  1  result aborted by timeout (tied 0 without the optional feature).
busy  output  1  high in LOADQ, LOADM and RUN.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, mul_start=0, mul_data_in=0, res_valid=0, res_data=0, res_err=0, operand registers=0, timeout counter=0. Reset mid-operation abandons the op. mul_start=0 puts the core back in s0 on the following edge. No result is produced.
- States: IDLE, LOADQ, LOADM, RUN.
- in_ready = (state==IDLE) && (!res_valid || res_ready), combinational.
- Accept: in_valid && in_ready at an edge latches in_mplr and in_mcand, then IDLE->LOADQ.
- LOADQ (1 cycle): mul_start=1, mul_data_in=multiplier register. The core is in s0 and samples it into Q. Next state is LOADM.
- LOADM (1 cycle): mul_start=1, mul_data_in=multiplicand register. The core is in s1 and samples it into M. Next state is RUN.
- RUN: mul_start=1, mul_data_in=0. Remains in RUN until mul_done=1 is sampled.
  - At that edge: res_data<=mul_product, res_valid<=1, res_err<=0, state<=IDLE.
  - mul_start drops in IDLE, which returns the core to s0.
- mul_start and mul_data_in are decoded combinationally from state and the operand registers. mul_start is low in IDLE.
- Result port:
  - res_valid stays high and res_data stays stable until res_valid && res_ready at an edge, which clears res_valid.
  - A new pair may be accepted in the same cycle the old result is consumed.
  - An op never overwrites an unconsumed result.
- mul_done outside RUN is ignored. in_valid while busy is not accepted because in_ready=0.
- Sign: the product is signed 2*WIDTH two's complement, passed through from the core unmodified. The block performs no arithmetic.
- Latency: accept edge to res_valid is 3 cycles plus the core's iteration time. With WIDTH=16 this is at most 3+3*16+1 cycles.

Optional Feature:
BOOTH_SEQ_TIMEOUT_EN.
- Defined: a counter clears on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT_CYCLES without mul_done, the block sets res_data<=0, res_err<=1, res_valid<=1, state<=IDLE and drops mul_start.
- mul_done and timeout in the same cycle: done wins, and res_err=0.
- Not defined: no counter is built, res_err is tied 0, and RUN waits indefinitely.

Test Plan:
- Reset, then check idle outputs: mul_start=0, res_valid=0, in_ready=1. Check that mul_data_in=0x0003 in LOADQ and 0x0005 in LOADM, then res_data=0x0000000F for in_mplr=3, in_mcand=5.
- in_mplr=0xFFFE (-2), in_mcand=7 -> res_data=0xFFFFFFF2. Also 0x8000 x 0x8000 -> 0x40000000.
- Backpressure: hold res_ready=0 after result 15. Offer a pair 2x2 -> in_ready=0, result stays 15. Raise res_ready -> same-edge accept of 2x2, next result 4.
- Assert rst in RUN -> mul_start=0 and res_valid=0 next cycle. A following 6x7 op yields 42.
- With BOOTH_SEQ_TIMEOUT_EN and a core model that never asserts done -> after TIMEOUT_CYCLES: res_valid=1, res_err=1, res_data=0, in_ready=1.
- Core model pulsing mul_done while IDLE -> no res_valid. Back-to-back 3 ops with res_ready=1 -> 3 results in order.

Source files
------------

// File: rtl/booth_op_sequencer.sv
// booth_op_sequencer: valid/ready front end that loads Q then M into the Booth core and returns its product.
// Optional BOOTH_SEQ_TIMEOUT_EN adds a RUN-state abort counter that reports a timeout through res_err.
module booth_op_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mplr,
  input  logic [WIDTH-1:0]     in_mcand,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_data_in,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_err,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LOADQ, LOADM, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mplr_q, mplr_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  logic res_valid_q, res_valid_d;
  logic accept, finish, abort;
  if (TIMEOUT_CYCLES < 3*WIDTH+4) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES is shorter than the core's worst-case run time");
  end
  assign in_ready = (state_q == IDLE) && (!res_valid_q || res_ready);
  assign accept   = in_valid && in_ready;
  assign finish   = (state_q == RUN) && mul_done;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic res_err_q, res_err_d;
  // done in the last allowed cycle still wins over the abort
  assign abort = (state_q == RUN) && !mul_done && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    cnt_d     = (state_q == LOADM) ? '0 : (state_q == RUN) ? cnt_q + 1'b1 : cnt_q;
    res_err_d = finish ? 1'b0 : abort ? 1'b1 : res_err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      res_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      res_err_q <= res_err_d;
    end
  end
  assign res_err = res_err_q;
`else
  assign abort   = 1'b0;
  assign res_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mplr_q      <= '0;
      mcand_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mplr_q      <= mplr_d;
      mcand_q     <= mcand_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
    end
  end
  always_comb begin
    state_d     = (state_q == IDLE)  ? (accept ? LOADQ : IDLE) :
                  (state_q == LOADQ) ? LOADM :
                  (state_q == LOADM) ? RUN :
                  (finish || abort)  ? IDLE : RUN;
    mplr_d      = accept ? in_mplr : mplr_q;
    mcand_d     = accept ? in_mcand : mcand_q;
    res_data_d  = finish ? mul_product : abort ? '0 : res_data_q;
    res_valid_d = (finish || abort) ? 1'b1 : (res_valid_q && res_ready) ? 1'b0 : res_valid_q;
  end
  // the core follows mul_start: low returns it to s0, so LOADQ always lands in Q
  always_comb begin
    mul_start   = state_q != IDLE;
    mul_data_in = (state_q == LOADQ) ? mplr_q : (state_q == LOADM) ? mcand_q : '0;
    busy        = state_q != IDLE;
  end
endmodule

// File: tb/tb_booth_op_sequencer.sv
// tb_booth_op_sequencer: scoreboard bench with a behavioural Booth core model and signed-multiply reference.
module tb_booth_op_sequencer;
  localparam int W = 16;
  typedef struct packed {logic [31:0] data; logic err;} exp_t;

  logic clk = 1'b0, rst;
  logic in_valid, in_ready, mul_start, mul_done, res_valid, res_ready, res_err, busy;
  logic [W-1:0] in_mplr, in_mcand, mul_data_in;
  logic [2*W-1:0] mul_product, res_data;

  exp_t exp_q[$];
  logic [31:0] op_q[$];
  int checks = 0, errors = 0;
  int rr_mode = 0;
  bit hang = 0, spur = 0, acc_with_valid;

  always #5 clk = ~clk;

  booth_op_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mplr(in_mplr), .in_mcand(in_mcand), .mul_start(mul_start),
    .mul_data_in(mul_data_in), .mul_done(mul_done), .mul_product(mul_product),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 32'(sa * sb);
  endfunction

  function automatic logic [15:0] rnd16();
    int k;
    k = $urandom_range(0, 6);
    return k == 0 ? 16'h8000 : k == 1 ? 16'h7FFF : k == 2 ? 16'hFFFF : k == 3 ? 16'h0000 : 16'($urandom);
  endfunction

  // Booth core stand-in: start low = s0, s0 samples Q, s1 samples M, then iterates a random time
  initial begin : core_model
    int phase, cnt;
    logic [15:0] q, m;
    logic [31:0] pair, np;
    logic nd;
    phase = 0; cnt = 0; q = '0; m = '0;
    mul_done = 1'b0; mul_product = '0;
    forever begin
      @(negedge clk);
      nd = 1'b0;
      np = mul_product;
      if (rst || !mul_start) begin
        phase = 0;
        nd = spur;
      end else if (phase == 0) begin
        q = mul_data_in;
        phase = 1;
      end else if (phase == 1) begin
        m = mul_data_in;
        phase = 2;
        cnt = $urandom_range(0, 45);
        if (op_q.size() == 0) chk("load_unexpected", 32'd1, 32'd0);
        else begin
          pair = op_q.pop_front();
          chk("load_q_mplr", {16'h0, q}, {16'h0, pair[31:16]});
          chk("load_m_mcand", {16'h0, m}, {16'h0, pair[15:0]});
        end
      end else if (phase == 2) begin
        chk("run_data_zero", {16'h0, mul_data_in}, 32'h0);
        if (!hang && cnt == 0) begin
          nd = 1'b1;
          np = ref_mul(q, m);
          phase = 3;
        end else if (!hang) cnt--;
      end else nd = 1'b1;
      @(posedge clk);
      #1;
      mul_done = nd;
      mul_product = np;
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid === 1'b1 && res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_err", {31'h0, res_err}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit to_err);
    int n;
    in_mplr = a; in_mcand = b; in_valid = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      acc_with_valid = res_valid;
      exp_q.push_back(to_err ? exp_t'{32'h0, 1'b1} : exp_t'{ref_mul(a, b), 1'b0});
      op_q.push_back({a, b});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !busy) && n < 500);
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int n;
    rst = 1'b1; in_valid = 1'b0; in_mplr = '0; in_mcand = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_start", {31'h0, mul_start}, 32'h0);
    chk("idle_res_valid", {31'h0, res_valid}, 32'h0);
    chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
    chk("idle_data_in", {16'h0, mul_data_in}, 32'h0);
    chk("idle_res_data", res_data, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    send(16'd3, 16'd5, 1'b0);
    chk("loadq_data", {16'h0, mul_data_in}, 32'h3);
    chk("loadq_start", {31'h0, mul_start}, 32'h1);
    @(posedge clk);
    #1;
    chk("loadm_data", {16'h0, mul_data_in}, 32'h5);
    wait_idle();
    send(16'hFFFE, 16'd7, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    wait_idle();
    chk("last_product", res_data, 32'h40000000);
    // backpressure: result held, new pair refused until consumed
    rr_mode = 2;
    @(posedge clk);
    #2;
    send(16'd3, 16'd5, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 200);
    in_mplr = 16'd2; in_mcand = 16'd2; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_res_valid", {31'h0, res_valid}, 32'h1);
      chk("bp_res_data", res_data, 32'hF);
    end
    rr_mode = 0;
    send(16'd2, 16'd2, 1'b0);
    chk("same_edge_accept", {31'h0, acc_with_valid}, 32'h1);
    wait_idle();
    chk("bp_next_result", res_data, 32'h4);
    // reset during RUN abandons the op
    hang = 1;
    send(16'd9, 16'd9, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pre_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; hang = 0;
    exp_q.delete();
    op_q.delete();
    @(negedge clk);
    chk("rst_start", {31'h0, mul_start}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    send(16'd6, 16'd7, 1'b0);
    wait_idle();
    chk("post_rst_product", res_data, 32'd42);
    // done pulses while idle must be ignored
    spur = 1;
    repeat (6) begin
      @(negedge clk);
      chk("spur_res_valid", {31'h0, res_valid}, 32'h0);
      chk("spur_busy", {31'h0, busy}, 32'h0);
    end
    spur = 0;
    repeat (3) @(posedge clk);
    #1;
    send(16'd11, 16'hFFF3, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h7FFF, 1'b0);
    wait_idle();
`ifdef BOOTH_SEQ_TIMEOUT_EN
    hang = 1;
    send(16'd1, 16'd1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 300);
    chk("to_res_valid", {31'h0, res_valid}, 32'h1);
    chk("to_in_ready", {31'h0, in_ready}, 32'h1);
    hang = 0;
    wait_idle();
`endif
    rr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(rnd16(), rnd16(), 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    rr_mode = 0;
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
